// File: rtl/mac_tx_frame_arbiter.sv
// Round-robin, frame-granular arbiter sharing one byte TX stream among N_REQ sources.
// Holds the grant from the first byte to eof, inserts an inter-frame gap and truncates long frames.
module mac_tx_frame_arbiter #(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned IFG_CYCLES = 2,
    parameter int unsigned MAX_LEN    = 1500,
    localparam int unsigned IDW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_eof,
    output logic [N_REQ-1:0]   req_ready,
    output logic               tx_valid,
    output logic [7:0]         tx_data,
    output logic               tx_eof,
    input  logic               tx_ready,
    output logic [IDW-1:0]     grant_id,
    output logic               busy,
    output logic               trunc_pulse
);

    localparam int unsigned CW = $clog2(MAX_LEN + 1);
    localparam int unsigned GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StGrant, StDrain, StGap} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] last_q, last_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic           trunc_q, trunc_d;

    logic             sel_valid, sel_eof, at_max, found;
    logic [7:0]       sel_data;
    logic [N_REQ-1:0] grant_mask;
    int unsigned      idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= IDW'(N_REQ - 1);
            cnt_q   <= '0;
            gap_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            trunc_q <= trunc_d;
        end
    end

    // Mux out the granted requester's stream.
    always_comb begin
        sel_valid  = 1'b0;
        sel_eof    = 1'b0;
        sel_data   = '0;
        grant_mask = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_q == IDW'(i)) begin
                sel_valid     = req_valid[i];
                sel_eof       = req_eof[i];
                sel_data      = req_data[8*i +: 8];
                grant_mask[i] = 1'b1;
            end
        end
    end

    assign at_max = (cnt_q == CW'(MAX_LEN - 1));

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        trunc_d   = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        tx_eof    = 1'b0;
        req_ready = '0;
        found     = 1'b0;
        idx       = 0;

        unique case (state_q)
            StIdle: begin
                // Search starts just after the last grant so every source gets a turn.
                for (int unsigned i = 1; i <= N_REQ; i++) begin
                    idx = (32'(last_q) + i) % N_REQ;
                    if (!found && req_valid[idx]) begin
                        found   = 1'b1;
                        grant_d = IDW'(idx);
                        last_d  = IDW'(idx);
                    end
                end
                if (found) begin
                    cnt_d   = '0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                tx_valid  = sel_valid;
                tx_data   = sel_data;
                tx_eof    = sel_eof | at_max;
                req_ready = grant_mask & {N_REQ{tx_ready}};
                if (sel_valid && tx_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (sel_eof) begin
                        gap_d   = '0;
                        state_d = (IFG_CYCLES == 0) ? StIdle : StGap;
                    end else if (at_max) begin
                        trunc_d = 1'b1;
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                req_ready = grant_mask;
                if (sel_valid && sel_eof) begin
                    gap_d   = '0;
                    state_d = (IFG_CYCLES == 0) ? StIdle : StGap;
                end
            end
            StGap: begin
                if (gap_q == GW'(IFG_CYCLES - 1)) begin
                    gap_d   = '0;
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy        = (state_q != StIdle);
    assign grant_id    = grant_q;
    assign trunc_pulse = trunc_q;

endmodule

// File: tb/tb_mac_tx_frame_arbiter.sv
// Randomized bench: AXI-style frame sources and random tx_ready, checked every cycle against
// an ownership/gap model of the arbiter built from the frame rules.
module tb_mac_tx_frame_arbiter;

    localparam int N   = 2;
    localparam int IFG = 2;
    localparam int ML  = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req_valid, req_eof, req_ready;
    logic [15:0]  req_data;
    logic         tx_valid, tx_eof, tx_ready, busy, trunc_pulse;
    logic [7:0]   tx_data;
    logic [0:0]   grant_id;

    always #5 clk = ~clk;

    mac_tx_frame_arbiter #(
        .N_REQ      (N),
        .IFG_CYCLES (IFG),
        .MAX_LEN    (ML)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_eof     (req_eof),
        .req_ready   (req_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_eof      (tx_eof),
        .tx_ready    (tx_ready),
        .grant_id    (grant_id),
        .busy        (busy),
        .trunc_pulse (trunc_pulse)
    );

    // Per-source pending bytes, {eof, data}.
    logic [8:0] src_q [N][$];

    // Model: who owns the stream, bytes sent, discarding tail, gap cycles still owed.
    int owner, sent, gap_left, last, gid;
    bit discard, trunc_exp;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input int obs, input int exp_v);
        n_vec++;
        if (obs != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        owner     = -1;
        sent      = 0;
        gap_left  = 0;
        last      = N - 1;
        gid       = 0;
        discard   = 1'b0;
        trunc_exp = 1'b0;
    endtask

    task automatic frame_done();
        owner    = -1;
        discard  = 1'b0;
        gap_left = IFG;
    endtask

    logic [1:0] exp_ready, xfer;
    logic       exp_valid;
    logic [8:0] tmp;
    bit         trunc_n, found;

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_eof   = '0;
        req_data  = '0;
        tx_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        for (int cyc = 0; cyc < 4000; cyc++) begin
            reset = ($urandom_range(0, 599) == 0);
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() == 0 && $urandom_range(0, 2) == 0) begin
                    automatic int len = $urandom_range(1, 12);
                    for (int b = 0; b < len; b++)
                        src_q[i].push_back({(b == len - 1), 8'($urandom)});
                end
                if (!req_valid[i] && src_q[i].size() > 0 && $urandom_range(0, 3) != 0) begin
                    tmp                 = src_q[i][0];
                    req_valid[i]        = 1'b1;
                    req_eof[i]          = tmp[8];
                    req_data[8*i +: 8]  = tmp[7:0];
                end
            end
            tx_ready = ($urandom_range(0, 3) != 0);
            #4;

            exp_ready = '0;
            exp_valid = 1'b0;
            if (owner >= 0 && !discard) begin
                exp_valid        = req_valid[owner];
                exp_ready[owner] = tx_ready;
            end else if (owner >= 0) begin
                exp_ready[owner] = 1'b1;
            end
            check_eq("busy", busy, (owner >= 0 || gap_left > 0));
            check_eq("grant_id", grant_id, gid);
            check_eq("trunc_pulse", trunc_pulse, trunc_exp);
            check_eq("tx_valid", tx_valid, exp_valid);
            check_eq("req_ready", req_ready, exp_ready);
            if (exp_valid) begin
                check_eq("tx_data", tx_data, req_data[8*owner +: 8]);
                check_eq("tx_eof", tx_eof, (req_eof[owner] || sent == ML - 1));
            end else if (owner < 0) begin
                check_eq("idle_data", tx_data, 0);
                check_eq("idle_eof", tx_eof, 0);
            end
            xfer = req_valid & exp_ready;

            @(posedge clk);
            if (reset) begin
                model_reset();
            end else begin
                trunc_n = 1'b0;
                if (owner < 0) begin
                    if (gap_left > 0) begin
                        gap_left--;
                    end else if (req_valid != 0) begin
                        found = 1'b0;
                        for (int k = 1; k <= N; k++) begin
                            automatic int c = (last + k) % N;
                            if (!found && req_valid[c]) begin
                                found = 1'b1;
                                owner = c;
                            end
                        end
                        last    = owner;
                        gid     = owner;
                        sent    = 0;
                        discard = 1'b0;
                    end
                end else if (!discard) begin
                    if (req_valid[owner] && tx_ready) begin
                        if (req_eof[owner]) begin
                            frame_done();
                        end else if (sent == ML - 1) begin
                            discard = 1'b1;
                            trunc_n = 1'b1;
                        end
                        sent++;
                    end
                end else if (req_valid[owner] && req_eof[owner]) begin
                    frame_done();
                end
                trunc_exp = trunc_n;
            end
            #1;
            for (int i = 0; i < N; i++) begin
                if (xfer[i]) begin
                    void'(src_q[i].pop_front());
                    req_valid[i] = 1'b0;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
